// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
//   Definitions shared by the I2S receiver and the 16-bit I2S master
//   transmitter: default word/slot geometry, the lrclk channel encoding and
//   the receiver framing-state encoding.
//
//   Contents:
//     I2S_DATA_W  default audio bits kept per channel
//     I2S_SLOT_W  default bclk periods per channel half-frame
//     LEFT/RIGHT  lrclk level selecting each channel
//     ST_*        receiver framing states
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int I2S_DATA_W = 16;
    localparam int I2S_SLOT_W = 32;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_CAP_L = 2'd1;
    localparam logic [1:0] ST_CAP_R = 2'd2;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//   Two-flop synchronizer for an asynchronous clock-like input, followed by a
//   third flop used to detect its rising edge in the clk domain.
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     din    in   asynchronous input
//     rise   out  one-clk pulse when the synchronized input goes 0 -> 1
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1_p0;
    logic s2_p1;
    logic s3_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
            s3_p2 <= 1'b0;
        end else begin
            s1_p0 <= din;
            s2_p1 <= s1_p0;
            s3_p2 <= s2_p1;
        end
    end

    assign rise = s2_p1 & ~s3_p2;

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
//   I2S slave receiver. Oversamples an externally driven bclk/lrclk/sdata
//   triple in the clk domain (clk >= 4x bclk) and emits one parallel
//   left/right sample pair per lrclk frame.
//
//   Parameters:
//     DATA_W  audio bits kept per channel, MSB first (DATA_W <= SLOT_W-1)
//     SLOT_W  nominal bclk periods per channel half-frame
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     audio_bclk   in   serial bit clock (asynchronous)
//     audio_lrclk  in   word select, 0 = left, 1 = right
//     audio_sdata  in   serial data, MSB one bclk after the lrclk change
//     out_ldata    out  left sample of the last complete frame
//     out_rdata    out  right sample of the last complete frame
//     out_valid    out  one-clk pulse when out_ldata/out_rdata update
//     frame_err    out  one-clk pulse on a framing violation
//     locked       out  high while capturing (CAP_L / CAP_R)
// -----------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W = I2S_DATA_W,
    parameter int SLOT_W = I2S_SLOT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              audio_bclk,
    input  logic              audio_lrclk,
    input  logic              audio_sdata,
    output logic [DATA_W-1:0] out_ldata,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_valid,
    output logic              frame_err,
    output logic              locked
);

    localparam int CNT_W = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LSB  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    // ---- stage p0/p1: input synchronizers ---------------------------------
    // lrclk and sdata go through the same two-flop depth as bclk, so on a
    // bclk_rise cycle they show the pin levels sampled together with bclk = 1.
    logic bclk_rise;
    logic lr_p0, lr_p1;
    logic sd_p0, sd_p1;

    sync_edge u_bclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (audio_bclk),
        .rise  (bclk_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lr_p0 <= 1'b0;
            lr_p1 <= 1'b0;
            sd_p0 <= 1'b0;
            sd_p1 <= 1'b0;
        end else begin
            lr_p0 <= audio_lrclk;
            lr_p1 <= lr_p0;
            sd_p0 <= audio_sdata;
            sd_p1 <= sd_p0;
        end
    end

    // ---- stage p2: framing FSM and shift register -------------------------
    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt, cnt_nxt;
    logic [DATA_W-1:0] shift_p2, shift_nxt;
    logic [DATA_W-1:0] left_hold, hold_nxt;
    logic              lr_prev, lr_prev_nxt;
    logic              vld_p2;
    logic              done;
    logic              err;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_cnt;
        shift_nxt   = shift_p2;
        hold_nxt    = left_hold;
        lr_prev_nxt = lr_prev;
        done        = 1'b0;
        err         = 1'b0;

        if (bclk_rise) begin
            if (lr_p1 != lr_prev) begin
                // Delay slot: carries the previous word's LSB, never stored.
                lr_prev_nxt = lr_p1;
                cnt_nxt     = '0;
                case (state)
                    ST_SEEK: begin
                        if (lr_p1 == LEFT) state_nxt = ST_CAP_L;
                    end
                    ST_CAP_L, ST_CAP_R: begin
                        if (bit_cnt >= CNT_DATA) begin
                            state_nxt = (lr_p1 == LEFT) ? ST_CAP_L : ST_CAP_R;
                        end else begin
                            // Short word. A left delay slot is still a valid
                            // frame start, so relock on it straight away.
                            err       = 1'b1;
                            state_nxt = (lr_p1 == LEFT) ? ST_CAP_L : ST_SEEK;
                        end
                    end
                    default: state_nxt = ST_SEEK;
                endcase
            end else if (state == ST_CAP_L || state == ST_CAP_R) begin
                cnt_nxt = sat_inc(bit_cnt);
                if (bit_cnt >= CNT_LAST) begin
                    // lrclk failed to toggle within the slot.
                    err       = 1'b1;
                    state_nxt = ST_SEEK;
                end
                if (bit_cnt < CNT_DATA) begin
                    shift_nxt = {shift_p2[DATA_W-2:0], sd_p1};
                    if (bit_cnt == CNT_LSB) begin
                        if (state == ST_CAP_L) hold_nxt = shift_nxt;
                        else                   done     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SEEK;
            bit_cnt   <= '0;
            shift_p2  <= '0;
            left_hold <= '0;
            lr_prev   <= RIGHT;
            vld_p2    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= cnt_nxt;
            shift_p2  <= shift_nxt;
            left_hold <= hold_nxt;
            lr_prev   <= lr_prev_nxt;
            vld_p2    <= done;
        end
    end

    // ---- stage p3: output register ----------------------------------------
    // shift_p2 cannot move in the cycle after done: the next bclk_rise is at
    // least four clk cycles away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ldata <= '0;
            out_rdata <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= vld_p2;
            frame_err <= err;
            if (vld_p2) begin
                out_ldata <= left_hold;
                out_rdata <= shift_p2;
            end
        end
    end

    assign locked = (state == ST_CAP_L) || (state == ST_CAP_R);

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx
//   Directed bench for i2s_rx. An I2S master is modelled in-line: bclk, lrclk
//   and sdata change on clk falling edges, bclk runs at clk/ratio, each
//   half-frame is one delay slot plus a number of data slots (31 for a
//   normal 32-slot half). Slots beyond the 16 kept bits, and the delay
//   slot itself, carry 1s that the receiver must discard.
//
//   Timing reference: slot_cyc[k] is the index of the first clk rising edge
//   that sees bclk = 1 for slot k of the last half sent (edge N). The receiver
//   registers out_valid on edge N+3 for right slot 16, so the pulse is the
//   level throughout cycle N+4; frame_err is registered on edge N+2 of the
//   offending slot. A monitor on the clk falling edge records both pulses
//   together with the index of the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_i2s_rx;

    logic        clk;
    logic        rst_n;
    logic        audio_bclk;
    logic        audio_lrclk;
    logic        audio_sdata;
    logic [15:0] out_ldata;
    logic [15:0] out_rdata;
    logic        out_valid;
    logic        frame_err;
    logic        locked;

    i2s_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_bclk  (audio_bclk),
        .audio_lrclk (audio_lrclk),
        .audio_sdata (audio_sdata),
        .out_ldata   (out_ldata),
        .out_rdata   (out_rdata),
        .out_valid   (out_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvalid = 0;
    int v_cyc  = -1;
    int nerr   = 0;
    int e_cyc  = -1;
    always @(negedge clk) begin
        if (out_valid) begin
            nvalid <= nvalid + 1;
            v_cyc  <= cyc;
        end
        if (frame_err) begin
            nerr  <= nerr + 1;
            e_cyc <= cyc;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int exp_valid   = 0;
    int ratio       = 8;
    int slot_cyc [0:63];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One channel half: delay slot (k = 0) then nd data slots.
    task automatic send_half(input logic lr, input logic [15:0] w, input int nd);
        for (int k = 0; k <= nd; k++) begin
            logic sd;
            if (k >= 1 && k <= 16) sd = w[4'(16 - k)];
            else                   sd = 1'b1;
            audio_bclk  = 1'b0;
            audio_lrclk = lr;
            audio_sdata = sd;
            repeat (ratio / 2) @(negedge clk);
            audio_bclk = 1'b1;
            if (k < 64) slot_cyc[k] = cyc + 1;
            repeat (ratio / 2) @(negedge clk);
        end
    endtask

    // Right half of a frame whose left half has been sent, then check it.
    task automatic right_and_check(input string tag, input logic [15:0] l, input logic [15:0] r);
        send_half(1'b1, r, 31);
        exp_valid++;
        chk({tag, "_cnt"}, 32'(nvalid), 32'(exp_valid));
        chk({tag, "_l"}, 32'(out_ldata), 32'(l));
        chk({tag, "_r"}, 32'(out_rdata), 32'(r));
        chk({tag, "_lat"}, 32'(v_cyc), 32'(slot_cyc[16] + 3));
    endtask

    task automatic do_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 31);
        right_and_check(tag, l, r);
    endtask

    initial begin
        rst_n       = 1'b0;
        audio_bclk  = 1'b0;
        audio_lrclk = 1'b1;
        audio_sdata = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_ldata", 32'(out_ldata), 32'h0);
        chk("rst_rdata", 32'(out_rdata), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_err",   32'(frame_err), 32'h0);
        chk("rst_lock",  32'(locked),    32'h0);

        // Release mid right word: no lock until the first 1->0 lrclk edge.
        rst_n = 1'b1;
        send_half(1'b1, 16'hFFFF, 20);
        chk("seek_lock",  32'(locked), 32'h0);
        chk("seek_valid", 32'(nvalid), 32'h0);
        send_half(1'b0, 16'hA5C3, 31);
        chk("first_l_lock",  32'(locked), 32'h1);
        chk("first_l_valid", 32'(nvalid), 32'h0);
        right_and_check("loop0", 16'hA5C3, 16'h3C5A);
        do_frame("loop1", 16'hA5C3, 16'h3C5A);
        do_frame("loop2", 16'hA5C3, 16'h3C5A);
        chk("loop_noerr", 32'(nerr), 32'h0);

        // Short left word: lrclk toggles after 10 data slots.
        send_half(1'b0, 16'h1234, 10);
        send_half(1'b1, 16'h5678, 31);
        chk("short_err",   32'(nerr),   32'h1);
        chk("short_ecyc",  32'(e_cyc),  32'(slot_cyc[0] + 2));
        chk("short_lock",  32'(locked), 32'h0);
        chk("short_valid", 32'(nvalid), 32'(exp_valid));
        do_frame("recover", 16'h0F0F, 16'hF0F0);

        // Stuck lrclk: 40 bclk at lr = 0, overflow on the 32nd data slot.
        send_half(1'b0, 16'hBEEF, 39);
        chk("stuck_err",   32'(nerr),   32'h2);
        chk("stuck_ecyc",  32'(e_cyc),  32'(slot_cyc[32] + 2));
        chk("stuck_lock",  32'(locked), 32'h0);
        chk("stuck_valid", 32'(nvalid), 32'(exp_valid));
        send_half(1'b1, 16'h0000, 31);
        do_frame("relock", 16'h1357, 16'h2468);

        // Reset during right-channel bit 7.
        send_half(1'b0, 16'hCAFE, 31);
        send_half(1'b1, 16'hD00D, 7);
        rst_n = 1'b0;
        #1;
        chk("mrst_ldata", 32'(out_ldata), 32'h0);
        chk("mrst_rdata", 32'(out_rdata), 32'h0);
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_err",   32'(frame_err), 32'h0);
        chk("mrst_lock",  32'(locked),    32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_half(1'b1, 16'hD00D, 24);
        chk("mrst_seek_lock",  32'(locked), 32'h0);
        chk("mrst_seek_valid", 32'(nvalid), 32'(exp_valid));
        do_frame("mrst_new", 16'hCAFE, 16'hD00D);

        // Walking ones at the minimum clk/bclk ratio.
        ratio = 4;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] lw;
            logic [15:0] rw;
            lw = 16'h0001 << i;
            rw = 16'h8000 >> i;
            do_frame($sformatf("walk%0d", i), lw, rw);
        end
        chk("total_err", 32'(nerr), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
